mem_burst_initiator: RTL

//  Client-side initiator for one mem_arbiter port (req/rw/addr/len/ack). Accepts one transfer

---
 rtl/mem_if_pkg.sv | 31 +++
 rtl/mem_burst_initiator_watchdog.sv | 30 +++
 rtl/mem_burst_initiator.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared memory-port definitions for mem_arbiter clients: widths, FSM encoding
// and small helpers for chunk sizing and address stepping.
package mem_if_pkg;

  localparam int unsigned ADDR_W            = 48;
  localparam int unsigned LEN_W             = 32;
  localparam int unsigned WORD_BYTES        = 8;
  localparam int unsigned WORD_SHIFT        = $clog2(WORD_BYTES);
  localparam int unsigned DEFAULT_N         = 4096;
  localparam int unsigned DEFAULT_MAX_CHUNK = 2 * DEFAULT_N;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_FIN
  } state_t;

  function automatic logic [LEN_W-1:0] chunk_len(input logic [LEN_W-1:0] remaining,
                                                 input logic [LEN_W-1:0] max_chunk);
    return (remaining > max_chunk) ? max_chunk : remaining;
  endfunction

  // Byte address of the next chunk; wraps modulo 2^48.
  function automatic logic [ADDR_W-1:0] advance_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [LEN_W-1:0]  words);
    return base + {{(ADDR_W-LEN_W-WORD_SHIFT){1'b0}}, words, {WORD_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_burst_initiator_watchdog.sv
// Request watchdog: loadable down-counter that flags expiry on the last
// cycle of the allowed wait window. TIMEOUT of 0 disables it entirely.
module mem_req_watchdog #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam logic        ENABLED  = (TIMEOUT != 0);
  localparam logic [31:0] LOAD_VAL = 32'(TIMEOUT);

  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 32'd1;
    end
  end

  assign expired = ENABLED && tick && (cnt == 32'd1);

endmodule

// File: rtl/mem_burst_initiator.sv
// Splits one transfer command into back-to-back arbiter requests of at most
// MAX_CHUNK words, with a per-request ack watchdog.
module mem_burst_initiator
  import mem_if_pkg::*;
#(
  parameter int unsigned N         = DEFAULT_N,
  parameter int unsigned MAX_CHUNK = 2 * N,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  output logic              busy,
  output logic [LEN_W-1:0]  chunk_off,
  output logic              done,
  output logic              err,
  output logic              req,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [LEN_W-1:0]  len,
  input  logic              ack
);

  localparam logic [LEN_W-1:0]  MAX_LEN    = LEN_W'(MAX_CHUNK);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] next_len;
  logic             wd_load;
  logic             wd_tick;
  logic             wd_expired;

  assign next_len = chunk_len(remaining, MAX_LEN);

  // The watchdog restarts on every edge that raises req into WAIT.
  assign wd_load = (state == ST_ISSUE) || ((state == ST_GAP) && !abort);
  assign wd_tick = (state == ST_WAIT);

  mem_req_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (wd_load),
    .tick   (wd_tick),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req       <= 1'b0;
      rw        <= 1'b0;
      addr      <= '0;
      len       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      chunk_off <= '0;
      cmd_ready <= 1'b1;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            rw        <= cmd_rw;
            addr      <= cmd_addr & ALIGN_MASK;
            remaining <= cmd_len;
            chunk_off <= '0;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= (cmd_len == '0) ? ST_FIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          len   <= next_len;
          req   <= 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ack) begin
            req       <= 1'b0;
            remaining <= remaining - len;
            addr      <= advance_addr(addr, len);
            chunk_off <= chunk_off + len;
            state     <= ((remaining == len) || abort) ? ST_FIN : ST_GAP;
          end else if (wd_expired) begin
            req   <= 1'b0;
            err   <= 1'b1;
            state <= ST_FIN;
          end
        end
        // GAP is the single req-low cycle between chunks, so it also performs
        // the issue step for follow-on chunks to keep the gap at one cycle.
        ST_GAP: begin
          if (abort) begin
            state <= ST_FIN;
          end else begin
            len   <= next_len;
            req   <= 1'b1;
            state <= ST_WAIT;
          end
        end
        ST_FIN: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          req       <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
